// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Two-port round-robin arbiter/sequencer in front of a single-port data
//   memory. Each requester issues one word read or write at a time. The block
//   grants one of them, holds the access on the memory for MEM_WAIT cycles,
//   captures read data and returns a one-cycle ack to the owner.
//
// Ports
//   clk, rst (asynchronous, active-low)
//   m0_req/m0_we/m0_adr/m0_wdata -> m0_ack/m0_rdata : requester 0
//   m1_req/m1_we/m1_adr/m1_wdata -> m1_ack/m1_rdata : requester 1
//   mem_adr/mem_wdata/mem_read/mem_write -> memory, mem_rdata <- memory
//   busy  : transaction in progress (state != IDLE)
//   owner : port owning the current/last transaction
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  // A wait of 0 would leave no cycle to present the access, so it is clamped.
  localparam int WAIT_EFF = (MEM_WAIT < 1) ? 1 : MEM_WAIT;
  // Counter only needs to hold WAIT_EFF-1.
  localparam int CW = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    w_req;
  logic          w_grant;
  logic          w_grant_port;
  logic          w_capture;
  logic          w_cnt_zero;
  logic [1:0]    w_ack;

  logic          r_owner;
  logic          r_last_owner;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rdata [2];

  assign w_req      = {m1_req, m0_req};
  // On a tie, the port that did not own the last transaction wins.
  assign w_grant_port = (&w_req) ? ~r_last_owner : w_req[1];
  assign w_cnt_zero = (r_cnt == '0);

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_grant      = 1'b1;
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_cnt_zero) begin
          w_capture    = ~r_we;
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request latch, wait counter and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;   // makes port 0 win the first tie after reset
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_port;
        r_we    <= w_grant_port ? m1_we    : m0_we;
        r_adr   <= w_grant_port ? m1_adr   : m0_adr;
        r_wdata <= w_grant_port ? m1_wdata : m0_wdata;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == S_ACCESS) && !w_cnt_zero) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == S_RESP) begin
        r_last_owner <= r_owner;
      end
    end
  end

  // Per-port read data registers and ack pulses
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rdata[gi] <= '0;
        end else if (w_capture && (r_owner == 1'(gi))) begin
          r_rdata[gi] <= mem_rdata;
        end
      end
      assign w_ack[gi] = (r_state == S_RESP) && (r_owner == 1'(gi));
    end
  endgenerate

  assign m0_ack    = w_ack[0];
  assign m1_ack    = w_ack[1];
  assign m0_rdata  = r_rdata[0];
  assign m1_rdata  = r_rdata[1];
  assign mem_adr   = r_adr;
  assign mem_wdata = r_wdata;
  // Read is held for the whole access; write only in its last cycle so the
  // memory sees a single write edge.
  assign mem_read  = (r_state == S_ACCESS) && !r_we;
  assign mem_write = (r_state == S_ACCESS) && r_we && w_cnt_zero;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Two arbiter instances (MEM_WAIT=1 and MEM_WAIT=3), each with a small
//   behavioural memory. A transaction-level timeline model predicts grants,
//   memory strobes, acks and read data every cycle.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l   [2];
  logic        init_pulse;
  logic        req     [2][2];
  logic        we      [2][2];
  logic [31:0] adr     [2][2];
  logic [31:0] wd      [2][2];
  logic        ackw    [2][2];
  logic [31:0] rdw     [2][2];
  logic [31:0] madr    [2];
  logic [31:0] mwd     [2];
  logic [31:0] mrd     [2];
  logic        mrdw    [2];
  logic        mwrw    [2];
  logic        busyw   [2];
  logic        ownw    [2];

  // model state
  int          g_edge  [2];
  logic        g_port  [2];
  logic        g_we    [2];
  logic [31:0] g_adr   [2];
  logic [31:0] g_wd    [2];
  logic        last_o  [2];
  logic        m_own   [2];
  logic [31:0] exp_rd  [2][2];
  logic [31:0] exp_madr[2];
  logic [31:0] exp_mwd [2];
  logic [31:0] ref_mem [2][16];
  logic        hold    [2][2];
  logic        rnd     [2];
  int          ecount;
  int          checks;
  int          failures;

  function automatic logic [31:0] init_val(input int i);
    return (i == 5) ? 32'h0000_1234 : 32'h0000_1000 + 32'(i);
  endfunction

  function automatic int mw(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [31:0] mem [16];

      data_mem_arbiter #(.AW(32), .DW(32), .MEM_WAIT((gi == 0) ? 1 : 3)) u_dut (
        .clk       (clk),
        .rst       (rst_l[gi]),
        .m0_req    (req[gi][0]),
        .m0_we     (we[gi][0]),
        .m0_adr    (adr[gi][0]),
        .m0_wdata  (wd[gi][0]),
        .m0_ack    (ackw[gi][0]),
        .m0_rdata  (rdw[gi][0]),
        .m1_req    (req[gi][1]),
        .m1_we     (we[gi][1]),
        .m1_adr    (adr[gi][1]),
        .m1_wdata  (wd[gi][1]),
        .m1_ack    (ackw[gi][1]),
        .m1_rdata  (rdw[gi][1]),
        .mem_adr   (madr[gi]),
        .mem_wdata (mwd[gi]),
        .mem_read  (mrdw[gi]),
        .mem_write (mwrw[gi]),
        .mem_rdata (mrd[gi]),
        .busy      (busyw[gi]),
        .owner     (ownw[gi])
      );

      assign mrd[gi] = mem[madr[gi][3:0]];

      always @(posedge clk) begin
        if (init_pulse) begin
          for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (mwrw[gi]) begin
          mem[madr[gi][3:0]] <= mwd[gi];
        end
      end
    end
  endgenerate

  function automatic logic [31:0] mem_rd(input int d, input int a);
    return (d == 0) ? g_dut[0].mem[a] : g_dut[1].mem[a];
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h edge=%0d", tag, d, obs, expv, ecount);
    end
  endtask

  // Timeline model: a grant can happen at an edge where the block is idle,
  // the access occupies MEM_WAIT cycles, the ack comes in the following cycle
  // and the next grant is possible two edges after the ack edge.
  task automatic model_check(input int d);
    int   k;
    logic in_tx, acc, resp;
    if (!rst_l[d]) begin
      g_edge[d]   = -1000;
      m_own[d]    = 1'b0;
      last_o[d]   = 1'b1;
      exp_rd[d][0] = '0;
      exp_rd[d][1] = '0;
      exp_madr[d] = '0;
      exp_mwd[d]  = '0;
    end else if ((g_edge[d] < 0 || ecount >= g_edge[d] + mw(d) + 2) && (req[d][0] || req[d][1])) begin
      g_port[d]   = (req[d][0] && req[d][1]) ? !last_o[d] : req[d][1];
      g_we[d]     = we[d][g_port[d]];
      g_adr[d]    = adr[d][g_port[d]];
      g_wd[d]     = wd[d][g_port[d]];
      m_own[d]    = g_port[d];
      last_o[d]   = g_port[d];
      exp_madr[d] = g_adr[d];
      exp_mwd[d]  = g_wd[d];
      g_edge[d]   = ecount;
    end
    k     = ecount - g_edge[d];
    in_tx = (g_edge[d] >= 0) && (k <= mw(d));
    acc   = (g_edge[d] >= 0) && (k < mw(d));
    resp  = (g_edge[d] >= 0) && (k == mw(d));
    if (resp) begin
      if (!g_we[d]) exp_rd[d][g_port[d]] = ref_mem[d][g_adr[d][3:0]];
      else          ref_mem[d][g_adr[d][3:0]] = g_wd[d];
      $display("txn dut%0d port%0d %s adr=%0h data=%h edge=%0d", d, g_port[d],
               g_we[d] ? "WR" : "RD", g_adr[d],
               g_we[d] ? g_wd[d] : ref_mem[d][g_adr[d][3:0]], ecount);
    end
    chk("busy",      d, busyw[d], in_tx);
    chk("mem_read",  d, mrdw[d],  acc && !g_we[d]);
    chk("mem_write", d, mwrw[d],  acc && g_we[d] && (k == mw(d) - 1));
    chk("m0_ack",    d, ackw[d][0], resp && (g_port[d] == 1'b0));
    chk("m1_ack",    d, ackw[d][1], resp && (g_port[d] == 1'b1));
    chk("m0_rdata",  d, rdw[d][0], exp_rd[d][0]);
    chk("m1_rdata",  d, rdw[d][1], exp_rd[d][1]);
    chk("owner",     d, ownw[d], m_own[d]);
    chk("mem_adr",   d, madr[d], exp_madr[d]);
    chk("mem_wdata", d, mwd[d],  exp_mwd[d]);
  endtask

  task automatic new_fields(input int d, input int p);
    we[d][p]  = 1'($urandom_range(0, 1));
    adr[d][p] = 32'($urandom_range(0, 15));
    wd[d][p]  = $urandom;
  endtask

  task automatic drive(input int d);
    for (int p = 0; p < 2; p++) begin
      if (rnd[d]) begin
        if (ackw[d][p]) begin
          req[d][p] = 1'($urandom_range(0, 1));
          new_fields(d, p);
        end else if (!req[d][p]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[d][p] = 1'b1;
            new_fields(d, p);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          adr[d][p] = 32'($urandom_range(0, 15));
        end
      end else if (ackw[d][p] && !hold[d][p]) begin
        req[d][p] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
    for (int d = 0; d < 2; d++) model_check(d);
    for (int d = 0; d < 2; d++) drive(d);
  endtask

  task automatic wait_ack(input int d, input int p, input int maxc, input string tag, output int at);
    logic found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < maxc && !found; i++) begin
      step();
      if (ackw[d][p]) begin
        found = 1'b1;
        at    = ecount;
      end
    end
    chk(tag, d, found, 1'b1);
  endtask

  task automatic wait_busy(input int d, input int maxc, input string tag, output int at);
    logic found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < maxc && !found; i++) begin
      step();
      if (busyw[d]) begin
        found = 1'b1;
        at    = ecount;
      end
    end
    chk(tag, d, found, 1'b1);
  endtask

  task automatic set_req(input int d, input int p, input logic w, input int a, input logic [31:0] v);
    req[d][p] = 1'b1;
    we[d][p]  = w;
    adr[d][p] = 32'(a);
    wd[d][p]  = v;
  endtask

  initial begin
    int   at_g, at_a, prev, port, idle_cnt;
    logic found;
    checks     = 0;
    failures   = 0;
    ecount     = 0;
    init_pulse = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst_l[d]  = 1'b0;
      rnd[d]    = 1'b0;
      g_edge[d] = -1000;
      g_port[d] = 1'b0;
      g_we[d]   = 1'b0;
      g_adr[d]  = '0;
      g_wd[d]   = '0;
      for (int p = 0; p < 2; p++) begin
        req[d][p]  = 1'b0;
        we[d][p]   = 1'b0;
        adr[d][p]  = '0;
        wd[d][p]   = '0;
        hold[d][p] = 1'b0;
      end
      for (int i = 0; i < 16; i++) ref_mem[d][i] = init_val(i);
    end

    // reset values
    step();
    init_pulse = 1'b0;
    step();
    rst_l[0] = 1'b1;
    rst_l[1] = 1'b1;

    // 1: m0 read adr 5, MEM_WAIT=1
    set_req(0, 0, 1'b0, 5, 32'h0);
    wait_busy(0, 5, "t1_grant_timeout", at_g);
    wait_ack(0, 0, 10, "t1_ack_timeout", at_a);
    chk("t1_latency", 0, 32'(at_a - at_g), 32'd1);
    chk("t1_rdata", 0, rdw[0][0], 32'h0000_1234);
    step();

    // 2: m1 write adr 7, then m0 reads it back
    set_req(0, 1, 1'b1, 7, 32'h0000_DEAD);
    wait_ack(0, 1, 10, "t2_wr_timeout", at_a);
    step();
    chk("t2_mem7", 0, mem_rd(0, 7), 32'h0000_DEAD);
    set_req(0, 0, 1'b0, 7, 32'h0);
    wait_ack(0, 0, 10, "t2_rd_timeout", at_a);
    chk("t2_rdata", 0, rdw[0][0], 32'h0000_DEAD);

    // 3: after reset, both requesting continuously -> 0,1,0,1 three cycles apart
    rst_l[0] = 1'b0;
    step();
    rst_l[0] = 1'b1;
    set_req(0, 0, 1'b0, 5, 32'h0);
    set_req(0, 1, 1'b0, 7, 32'h0);
    hold[0][0] = 1'b1;
    hold[0][1] = 1'b1;
    prev = -1;
    for (int n = 0; n < 4; n++) begin
      found = 1'b0;
      port  = -1;
      for (int i = 0; i < 12 && !found; i++) begin
        step();
        if (ackw[0][0] || ackw[0][1]) begin
          found = 1'b1;
          port  = ackw[0][1] ? 1 : 0;
        end
      end
      chk("t3_ack_timeout", 0, found, 1'b1);
      chk("t3_owner_seq", 0, 32'(port), 32'(n % 2));
      if (n > 0) chk("t3_ack_gap", 0, 32'(ecount - prev), 32'd3);
      prev = ecount;
    end
    hold[0][0] = 1'b0;
    hold[0][1] = 1'b0;
    repeat (10) step();

    // 6: m0 alone holding req across 4 transactions
    set_req(0, 0, 1'b0, 7, 32'h0);
    hold[0][0] = 1'b1;
    prev     = -1;
    idle_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
        step();
        if (prev >= 0 && !busyw[0]) idle_cnt++;
        if (ackw[0][0]) found = 1'b1;
      end
      chk("t6_ack_timeout", 0, found, 1'b1);
      if (n > 0) chk("t6_ack_gap", 0, 32'(ecount - prev), 32'(mw(0) + 2));
      prev = ecount;
    end
    chk("t6_idle_cycles", 0, 32'(idle_cnt), 32'd3);
    hold[0][0] = 1'b0;
    repeat (5) step();

    // 4: MEM_WAIT=3 write, address change during access ignored
    set_req(1, 0, 1'b1, 3, 32'h0000_BEEF);
    wait_busy(1, 5, "t4_grant_timeout", at_g);
    adr[1][0] = 32'd9;
    wait_ack(1, 0, 10, "t4_ack_timeout", at_a);
    chk("t4_latency", 1, 32'(at_a - at_g), 32'd3);
    chk("t4_mem3", 1, mem_rd(1, 3), 32'h0000_BEEF);
    chk("t4_mem9", 1, mem_rd(1, 9), 32'h0000_1009);
    step();

    // 5: reset in the middle of a write
    set_req(1, 0, 1'b1, 4, 32'h0000_CAFE);
    wait_busy(1, 5, "t5_grant_timeout", at_g);
    step();
    rst_l[1] = 1'b0;
    #1;
    chk("t5_busy_async", 1, busyw[1], 1'b0);
    chk("t5_write_async", 1, mwrw[1], 1'b0);
    chk("t5_read_async", 1, mrdw[1], 1'b0);
    chk("t5_adr_async", 1, madr[1], 32'h0);
    chk("t5_wdata_async", 1, mwd[1], 32'h0);
    req[1][0] = 1'b0;
    step();
    step();
    rst_l[1] = 1'b1;
    chk("t5_mem4", 1, mem_rd(1, 4), 32'h0000_1004);
    set_req(1, 0, 1'b0, 3, 32'h0);
    set_req(1, 1, 1'b0, 3, 32'h0);
    found = 1'b0;
    port  = -1;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (ackw[1][0] || ackw[1][1]) begin
        found = 1'b1;
        port  = ackw[1][1] ? 1 : 0;
      end
    end
    chk("t5_first_timeout", 1, found, 1'b1);
    chk("t5_first_port", 1, 32'(port), 32'd0);
    wait_ack(1, 1, 12, "t5_m1_timeout", at_a);
    chk("t5_m1_rdata", 1, rdw[1][1], 32'h0000_BEEF);
    repeat (3) step();

    // randomized traffic on both instances
    rnd[0] = 1'b1;
    rnd[1] = 1'b1;
    repeat (400) step();
    rnd[0] = 1'b0;
    rnd[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d][0] = 1'b0;
      req[d][1] = 1'b0;
    end
    repeat (10) step();

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        chk("final_mem", d, mem_rd(d, i), ref_mem[d][i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
